// File: rtl/reduction_gate_sweeper_if.sv
// Bus interface for reduction_gate_sweeper.
//   master side (stimulus owner) drives : start, mode, ext_in
//   slave side  (the sweeper)    drives : pattern, result, result_valid,
//                                         ones_count, busy, done
// WIDTH must match the WIDTH of the sweeper it connects to.
interface reduction_gate_sweeper_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] ext_in;
    logic [WIDTH-1:0] pattern;
    logic             result;
    logic             result_valid;
    logic [WIDTH:0]   ones_count;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, ext_in,
        input  pattern, result, result_valid, ones_count, busy, done
    );

    modport slave (
        input  start, mode, ext_in,
        output pattern, result, result_valid, ones_count, busy, done
    );
endinterface

// File: rtl/reduction_gate_sweeper.sv
// reduction_gate_sweeper
// N-input reduction gate (AND/OR/XOR/NAND/NOR/XNOR) with a built-in
// exhaustive sweeper. A start in IDLE walks every WIDTH-bit pattern,
// holding each for DWELL cycles, and counts the patterns whose gate
// output is 1. While not sweeping the gate evaluates ext_in directly.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : reduction_gate_sweeper_if.slave
//            start, mode[2:0], ext_in[WIDTH-1:0]          (inputs)
//            pattern, result, result_valid, ones_count,
//            busy, done                                    (outputs)
// mode: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 output 0.
module reduction_gate_sweeper #(
    parameter int WIDTH = 4,
    parameter int DWELL = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    reduction_gate_sweeper_if.slave bus
);

    // Counter is at least one bit wide so DWELL=1 still elaborates.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]    LAST = CW'(DWELL - 1);
    localparam logic [WIDTH-1:0] PMAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2:0]       lmode;
    logic [WIDTH-1:0] in_vec;
    logic [2:0]       act_mode;

    function automatic logic gate_f(input logic [2:0] m, input logic [WIDTH-1:0] v);
        case (m)
            3'd0:    gate_f = &v;
            3'd1:    gate_f = |v;
            3'd2:    gate_f = ^v;
            3'd3:    gate_f = ~&v;
            3'd4:    gate_f = ~|v;
            3'd5:    gate_f = ~^v;
            default: gate_f = 1'b0;
        endcase
    endfunction

    // The sweep owns the gate inputs and function only while RUN; in IDLE
    // and in the single DONE cycle the live ext_in/mode are evaluated.
    always_comb begin
        in_vec   = bus.ext_in;
        act_mode = bus.mode;
        if (bus.busy) begin
            in_vec   = bus.pattern;
            act_mode = lmode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            lmode            <= '0;
            bus.pattern      <= '0;
            bus.result       <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.ones_count   <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.result       <= gate_f(act_mode, in_vec);
            bus.result_valid <= 1'b0;
            bus.done         <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state          <= RUN;
                        bus.busy       <= 1'b1;
                        lmode          <= bus.mode;
                        bus.pattern    <= '0;
                        cnt            <= '0;
                        bus.ones_count <= '0;
                    end
                end

                RUN: begin
                    if (cnt == LAST) begin
                        // End-of-dwell sample: the result register is loaded
                        // with the same f(lmode, pattern) on this edge, so
                        // result_valid and result line up.
                        bus.result_valid <= 1'b1;
                        bus.ones_count   <= bus.ones_count +
                                            (WIDTH+1)'(gate_f(lmode, bus.pattern));
                        if (bus.pattern != PMAX) begin
                            bus.pattern <= bus.pattern + 1'b1;
                            cnt         <= '0;
                        end else begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reduction_gate_sweeper.sv
module tb_reduction_gate_sweeper;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    reduction_gate_sweeper_if #(.WIDTH(4)) bus4 ();
    reduction_gate_sweeper_if #(.WIDTH(3)) bus3 ();

    reduction_gate_sweeper #(.WIDTH(4), .DWELL(20)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    reduction_gate_sweeper #(.WIDTH(3), .DWELL(1)) u3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference gate: defined on the number of ones in the vector.
    function automatic int ref_f(input int m, input int v, input int w);
        int pc;
        pc = 0;
        for (int i = 0; i < w; i++) pc += (v >> i) & 1;
        case (m)
            0:       return (pc == w) ? 1 : 0;
            1:       return (pc != 0) ? 1 : 0;
            2:       return pc % 2;
            3:       return (pc != w) ? 1 : 0;
            4:       return (pc == 0) ? 1 : 0;
            5:       return 1 - (pc % 2);
            default: return 0;
        endcase
    endfunction

    function automatic int ref_ones(input int m, input int w);
        int s;
        s = 0;
        for (int v = 0; v < (1 << w); v++) s += ref_f(m, v, w);
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] mode;
        logic [3:0] ext;
        logic       exp;
    } idle_vec_t;

    typedef struct {
        logic [2:0] mode;
        int         exp_ones;
    } sweep_vec_t;

    // WIDTH=4/DWELL=20 sweep; optionally changes mode and pulses start mid-run.
    task automatic sweep4(input logic [2:0] m, input int exp_ones,
                          input int chg_at, input int pulse_at);
        int busy_n, vcnt, last_v, first_v, done_c, extra_done;
        int bad_res, bad_sp, bad_hold;
        busy_n = 0; vcnt = 0; last_v = -1; first_v = -1; done_c = -1;
        bad_res = 0; bad_sp = 0; extra_done = 0; bad_hold = 0;
        @(negedge clk);
        bus4.mode  = m;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (bus4.busy) busy_n++;
            if (bus4.result_valid) begin
                if (int'(bus4.result) != ref_f(m, vcnt, 4)) bad_res++;
                if (first_v < 0) first_v = c;
                else if (c - last_v != 20) bad_sp++;
                last_v = c;
                vcnt++;
            end
            if (bus4.done) begin
                done_c = c;
                check("done_with_valid", int'(bus4.result_valid), 1);
                check("busy_low_at_done", int'(bus4.busy), 0);
                check("pattern_at_done", int'(bus4.pattern), 15);
                break;
            end
            bus4.mode  = (c >= chg_at && chg_at >= 0) ? ((m == 3'd0) ? 3'd1 : 3'd0) : m;
            bus4.start = (c == pulse_at) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        bus4.start = 1'b0;
        check("done_cycle", done_c, 320);
        check("busy_cycles", busy_n, 320);
        check("valid_pulses", vcnt, 16);
        check("first_valid", first_v, 20);
        check("valid_spacing_errs", bad_sp, 0);
        check("sweep_result_errs", bad_res, 0);
        check($sformatf("ones_count_m%0d", m), int'(bus4.ones_count), exp_ones);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus4.done) extra_done++;
            if (bus4.busy || bus4.pattern != 4'd15 ||
                int'(bus4.ones_count) != exp_ones) bad_hold++;
        end
        check("extra_done", extra_done, 0);
        check("hold_after_done", bad_hold, 0);
        bus4.mode = m;
    endtask

    // WIDTH=3/DWELL=1 sweep: one pattern per cycle.
    task automatic sweep3(input logic [2:0] m, input int exp_ones);
        int busy_n, vcnt, last_v, first_v, done_c, bad_res, bad_sp;
        busy_n = 0; vcnt = 0; last_v = -1; first_v = -1; done_c = -1;
        bad_res = 0; bad_sp = 0;
        @(negedge clk);
        bus3.mode  = m;
        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus3.busy) busy_n++;
            if (bus3.result_valid) begin
                if (int'(bus3.result) != ref_f(m, vcnt, 3)) bad_res++;
                if (first_v < 0) first_v = c;
                else if (c - last_v != 1) bad_sp++;
                last_v = c;
                vcnt++;
            end
            if (bus3.done) begin
                done_c = c;
                break;
            end
            @(negedge clk);
        end
        check("w3_done_cycle", done_c, 8);
        check("w3_busy_cycles", busy_n, 8);
        check("w3_valid_pulses", vcnt, 8);
        check("w3_first_valid", first_v, 1);
        check("w3_consecutive_errs", bad_sp, 0);
        check("w3_result_errs", bad_res, 0);
        check($sformatf("w3_ones_m%0d", m), int'(bus3.ones_count), exp_ones);
        check("w3_pattern_at_done", int'(bus3.pattern), 7);
    endtask

    initial begin
        idle_vec_t  idle_tab[11];
        sweep_vec_t sweep_tab[6];
        int         dn;
        logic [2:0] rm;
        logic [3:0] rv;

        idle_tab = '{
            '{3'd1, 4'b0000, 1'b0}, '{3'd1, 4'b0100, 1'b1},
            '{3'd0, 4'b1111, 1'b1}, '{3'd0, 4'b1110, 1'b0},
            '{3'd2, 4'b0111, 1'b1}, '{3'd2, 4'b0110, 1'b0},
            '{3'd3, 4'b1111, 1'b0}, '{3'd4, 4'b0000, 1'b1},
            '{3'd5, 4'b0011, 1'b1}, '{3'd6, 4'b1111, 1'b0},
            '{3'd7, 4'b1111, 1'b0}
        };
        sweep_tab = '{
            '{3'd1, 15}, '{3'd0, 1}, '{3'd2, 8},
            '{3'd4, 1},  '{3'd5, 8}, '{3'd6, 0}
        };

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus4.start = 1'b0; bus4.mode = 3'd0; bus4.ext_in = 4'hF;
        bus3.start = 1'b0; bus3.mode = 3'd0; bus3.ext_in = 3'h0;

        repeat (3) @(negedge clk);
        check("rst_pattern", int'(bus4.pattern), 0);
        check("rst_result", int'(bus4.result), 0);
        check("rst_valid", int'(bus4.result_valid), 0);
        check("rst_ones", int'(bus4.ones_count), 0);
        check("rst_busy", int'(bus4.busy), 0);
        check("rst_done", int'(bus4.done), 0);
        rst_n = 1'b1;

        // Direct path in IDLE: one-cycle latency, never valid.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus4.mode   = idle_tab[i].mode;
            bus4.ext_in = idle_tab[i].ext;
            @(negedge clk);
            check($sformatf("idle_tab%0d", i), int'(bus4.result), int'(idle_tab[i].exp));
            check("idle_valid", int'(bus4.result_valid), 0);
        end

        for (int i = 0; i < 20; i++) begin
            rm = 3'($urandom_range(0, 7));
            rv = 4'($urandom);
            @(negedge clk);
            bus4.mode   = rm;
            bus4.ext_in = rv;
            @(negedge clk);
            check($sformatf("idle_rand_m%0d_v%0d", rm, rv), int'(bus4.result),
                  ref_f(int'(rm), int'(rv), 4));
        end

        for (int i = 0; i < 6; i++) begin
            bus4.ext_in = 4'($urandom);
            sweep4(sweep_tab[i].mode, sweep_tab[i].exp_ones, -1, -1);
        end

        // Mode change at cycle 50 and a start pulse at cycle 100 are ignored.
        sweep4(3'd1, 15, 50, 100);

        // Asynchronous reset mid-sweep.
        @(negedge clk);
        bus4.mode  = 3'd1;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (150) @(negedge clk);
        check("pre_rst_busy", int'(bus4.busy), 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(bus4.busy), 0);
        check("arst_pattern", int'(bus4.pattern), 0);
        check("arst_ones", int'(bus4.ones_count), 0);
        dn = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus4.done) dn++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus4.done || bus4.busy) dn++;
        end
        check("arst_no_done", dn, 0);
        sweep4(3'd1, 15, -1, -1);

        // WIDTH=3, DWELL=1.
        sweep3(3'd3, 7);
        for (int i = 0; i < 4; i++) begin
            rm = 3'($urandom_range(0, 7));
            sweep3(rm, ref_ones(int'(rm), 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
